// File: rtl/aes_dec_top.sv
// ============================================================================
// Module   : aes_dec_top (with helper aes_dec_sbox)
// Brief    : Iterative AES-128 inverse cipher. Keys are expanded on chip and
//            then ten inverse rounds run at one round per clock.
// Option   : AES_DEC_KEYCACHE_EN skips key expansion on a repeated key.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_dec_sbox #(
   parameter bit INVERSE = 1'b1
) (
   input  logic [7:0] din,
   output logic [7:0] dout
);

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = '0;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xt(aa);
      end
      return p;
   endfunction

   // x^254 is the multiplicative inverse and maps 0 to 0
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = gf_mul(a, a);
      acc = sq;
      for (int i = 0; i < 6; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   function automatic logic [7:0] fwd_aff(input logic [7:0] a);
      return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]}
               ^ {a[3:0], a[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_aff(input logic [7:0] a);
      return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
   endfunction

   generate
      if (INVERSE) begin : g_inv
         assign dout = gf_inv(inv_aff(din));
      end else begin : g_fwd
         assign dout = fwd_aff(gf_inv(din));
      end
   endgenerate

endmodule

module aes_dec_top (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key,
   input  logic [127:0] ciphertext,
   output logic         busy,
   output logic         done,
   output logic [127:0] plaintext
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_KEYEXP = 3'd1,
      S_INIT   = 3'd2,
      S_ROUND  = 3'd3,
      S_FIN    = 3'd4
   } state_t;

   state_t        r_state;
   state_t        w_state_nx;
   logic [3:0]    r_round;
   logic [127:0]  r_rk [0:10];
   logic [127:0]  r_ct;
   logic [127:0]  r_s;
   logic [127:0]  r_pt;
   logic          r_done;
   logic          w_cache_hit;

   logic [127:0]  w_prev;
   logic [31:0]   w_rot;
   logic [31:0]   w_sub;
   logic [31:0]   w_temp;
   logic [31:0]   w_n0, w_n1, w_n2, w_n3;
   logic [127:0]  w_rk_next;
   logic [127:0]  w_isr;
   logic [127:0]  w_isb;
   logic [127:0]  w_ark;
   logic [127:0]  w_imc;

   function automatic logic [7:0] rcon(input logic [3:0] i);
      case (i)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
      logic [7:0] a [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] x2, x4, x8;
      for (int i = 0; i < 4; i++) begin
         a[i]  = c[31-8*i -: 8];
         x2    = xt(a[i]);
         x4    = xt(x2);
         x8    = xt(x4);
         m9[i] = x8 ^ a[i];
         mb[i] = x8 ^ x2 ^ a[i];
         md[i] = x8 ^ x4 ^ a[i];
         me[i] = x8 ^ x4 ^ x2;
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   // Key schedule step: rk[r_round] from rk[r_round-1]
   assign w_prev    = r_rk[r_round - 4'd1];
   assign w_rot     = {w_prev[23:0], w_prev[31:24]};
   assign w_temp    = w_sub ^ {rcon(r_round), 24'h0};
   assign w_n0      = w_prev[127:96] ^ w_temp;
   assign w_n1      = w_prev[95:64]  ^ w_n0;
   assign w_n2      = w_prev[63:32]  ^ w_n1;
   assign w_n3      = w_prev[31:0]   ^ w_n2;
   assign w_rk_next = {w_n0, w_n1, w_n2, w_n3};

   generate
      for (genvar k = 0; k < 4; k++) begin : g_ks_sbox
         aes_dec_sbox #(.INVERSE(1'b0)) u_sbox (
            .din  (w_rot[31-8*k -: 8]),
            .dout (w_sub[31-8*k -: 8])
         );
      end

      // Byte i sits at row i%4, column i/4; row r rotates right by r
      for (genvar i = 0; i < 16; i++) begin : g_bytes
         localparam int ROW = i % 4;
         localparam int COL = i / 4;
         localparam int SRC = ROW + 4 * ((COL - ROW + 4) % 4);
         assign w_isr[127-8*i -: 8] = r_s[127-8*SRC -: 8];
         aes_dec_sbox #(.INVERSE(1'b1)) u_sbox (
            .din  (w_isr[127-8*i -: 8]),
            .dout (w_isb[127-8*i -: 8])
         );
      end

      for (genvar c = 0; c < 4; c++) begin : g_imc
         assign w_imc[127-32*c -: 32] = inv_mix_col(w_ark[127-32*c -: 32]);
      end
   endgenerate

   // r_round reaches 0 after the last ROUND, so FIN adds rk[0] here too
   assign w_ark = w_isb ^ r_rk[r_round];

`ifdef AES_DEC_KEYCACHE_EN
   logic r_cache_valid;

   // rk[0] is only rewritten on a miss, so it doubles as the cached key
   assign w_cache_hit = r_cache_valid && (key == r_rk[0]);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cache_valid <= 1'b0;
      end else if (r_state == S_IDLE && start && !w_cache_hit) begin
         r_cache_valid <= 1'b0;
      end else if (r_state == S_KEYEXP && r_round == 4'd10) begin
         r_cache_valid <= 1'b1;
      end
   end
`else
   assign w_cache_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         S_IDLE:   if (start) w_state_nx = w_cache_hit ? S_INIT : S_KEYEXP;
         S_KEYEXP: if (r_round == 4'd10) w_state_nx = S_INIT;
         S_INIT:   w_state_nx = S_ROUND;
         S_ROUND:  if (r_round == 4'd1) w_state_nx = S_FIN;
         S_FIN:    w_state_nx = S_IDLE;
         default:  w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      case (r_state)
         S_IDLE: begin
            if (start) begin
               r_ct    <= ciphertext;
               r_round <= 4'd1;
               if (!w_cache_hit) r_rk[0] <= key;
            end
         end
         S_KEYEXP: begin
            r_rk[r_round] <= w_rk_next;
            r_round       <= r_round + 4'd1;
         end
         S_INIT: begin
            r_s     <= r_ct ^ r_rk[10];
            r_round <= 4'd9;
         end
         S_ROUND: begin
            r_s     <= w_imc;
            r_round <= r_round - 4'd1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_done <= 1'b0;
         r_pt   <= '0;
      end else begin
         r_done <= (r_state == S_FIN);
         if (r_state == S_FIN) r_pt <= w_ark;
      end
   end

   assign busy      = (r_state != S_IDLE);
   assign done      = r_done;
   assign plaintext = r_pt;

endmodule

`default_nettype wire

// File: tb/tb_aes_dec_top.sv
// ============================================================================
// Module   : tb_aes_dec_top
// Brief    : Self-checking bench for aes_dec_top with a plaintext scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_dec_top;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [127:0] key;
   logic [127:0] ciphertext;
   logic         busy;
   logic         done;
   logic [127:0] plaintext;

   int errors = 0;
   int checks = 0;
   logic [127:0] exp_q [$];
   int           due_q [$];

   // Reference model of the key cache, used only to predict latency
   bit           m_valid = 1'b0;
   logic [127:0] m_key   = '0;
`ifdef AES_DEC_KEYCACHE_EN
   localparam bit CACHE = 1'b1;
`else
   localparam bit CACHE = 1'b0;
`endif

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

   aes_dec_top dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .key        (key),
      .ciphertext (ciphertext),
      .busy       (busy),
      .done       (done),
      .plaintext  (plaintext)
   );

   always #5 clk = ~clk;

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   function automatic int exp_lat(input logic [127:0] k);
      return (CACHE && m_valid && k == m_key) ? 11 : 21;
   endfunction

   task automatic pop_check(input string name);
      logic [127:0] pe;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: unexpected done, scoreboard empty, got %h", name, plaintext);
      end else begin
         pe = exp_q.pop_front();
         if (plaintext !== pe) begin
            errors++;
            $display("FAIL %s: plaintext got %h expected %h", name, plaintext, pe);
         end
      end
   endtask

   task automatic run_block(input string name, input logic [127:0] k,
                            input logic [127:0] c, input logic [127:0] p);
      int lat;
      int n;
      bit seen;
      lat = exp_lat(k);
      key = k;
      ciphertext = c;
      start = 1'b1;
      exp_q.push_back(p);
      cyc;
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL %s_busy: got %b expected 1", name, busy);
      end
      n = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         cyc;
         n++;
         if (done === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen || n != lat) begin
         errors++;
         $display("FAIL %s_latency: got %0d (seen=%0b) expected %0d", name, n, seen, lat);
      end
      if (seen) pop_check(name);
      else void'(exp_q.pop_front());
      m_valid = 1'b1;
      m_key = k;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      start = 1'b0;
      key = '0;
      ciphertext = '0;
      cyc;
      cyc;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++;
      if (plaintext !== '0) begin errors++; $display("FAIL reset_pt: got %h expected 0", plaintext); end
      rst = 1'b0;
      m_valid = 1'b0;
      cyc;
   endtask

   task automatic test_fips_c1;
      run_block("fips_c1", C1_KEY, C1_CT, C1_PT);
   endtask

   task automatic test_fips_b_hold;
      bit stable;
      bit extra_done;
      run_block("fips_b", B_KEY, B_CT, B_PT);
      stable = 1'b1;
      extra_done = 1'b0;
      key = C1_KEY;
      ciphertext = C1_CT;
      for (int i = 0; i < 8; i++) begin
         cyc;
         if (plaintext !== B_PT) stable = 1'b0;
         if (done !== 1'b0) extra_done = 1'b1;
      end
      checks++;
      if (!stable) begin errors++; $display("FAIL hold_pt: got %h expected %h", plaintext, B_PT); end
      checks++;
      if (extra_done) begin errors++; $display("FAIL hold_done: got 1 expected 0"); end
   endtask

   task automatic test_start_ignored;
      int lat;
      int dones;
      int first;
      logic [127:0] pt_at_done;
      lat = exp_lat(C1_KEY);
      key = C1_KEY;
      ciphertext = C1_CT;
      start = 1'b1;
      exp_q.push_back(C1_PT);
      cyc;
      start = 1'b0;
      dones = 0;
      first = -1;
      pt_at_done = '0;
      for (int n = 1; n <= 45; n++) begin
         start = (n == 5);
         if (n == 5) begin
            key = B_KEY;
            ciphertext = B_CT;
         end
         cyc;
         if (done === 1'b1) begin
            dones++;
            if (first < 0) begin
               first = n;
               pop_check("ignored_pt");
            end
         end
      end
      start = 1'b0;
      checks++;
      if (dones != 1) begin errors++; $display("FAIL ignored_dones: got %0d expected 1", dones); end
      checks++;
      if (first != lat) begin errors++; $display("FAIL ignored_latency: got %0d expected %0d", first, lat); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL ignored_busy: got %b expected 0", busy); end
      m_valid = 1'b1;
      m_key = C1_KEY;
   endtask

   task automatic test_reset_mid;
      bit any_done;
      key = B_KEY;
      ciphertext = B_CT;
      start = 1'b1;
      cyc;
      start = 1'b0;
      for (int n = 1; n <= 7; n++) cyc;
      rst = 1'b1;
      cyc;
      rst = 1'b0;
      m_valid = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", done); end
      checks++;
      if (plaintext !== '0) begin errors++; $display("FAIL midrst_pt: got %h expected 0", plaintext); end
      any_done = 1'b0;
      for (int n = 0; n < 30; n++) begin
         cyc;
         if (done !== 1'b0) any_done = 1'b1;
      end
      checks++;
      if (any_done) begin errors++; $display("FAIL midrst_nodone: got done expected none"); end
      run_block("after_rst_c1", C1_KEY, C1_CT, C1_PT);
   endtask

   task automatic test_back_to_back;
      logic [127:0] cts [4];
      logic [127:0] pts [4];
      int issued;
      int got;
      int cyc_n;
      int due;
      bit acc;
      cts[0] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
      pts[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
      cts[1] = 128'hf5d3d58503b9699de785895a96fdbaaf;
      pts[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
      cts[2] = 128'h43b1cd7f598ece23881b00e3ed030688;
      pts[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
      cts[3] = 128'h7b0c785e27e8ad3f8223207104725dd4;
      pts[3] = 128'hf69f2445df4f9b17ad2b417be66c3710;
      issued = 0;
      got = 0;
      cyc_n = 0;
      key = B_KEY;
      ciphertext = cts[0];
      start = 1'b1;
      while (got < 4 && cyc_n < 300) begin
         acc = start && (busy === 1'b0);
         cyc;
         cyc_n++;
         if (acc) begin
            exp_q.push_back(pts[issued]);
            due_q.push_back(cyc_n + exp_lat(B_KEY));
            m_valid = 1'b1;
            m_key = B_KEY;
            issued++;
            if (issued < 4) ciphertext = cts[issued];
            else start = 1'b0;
         end
         if (done === 1'b1) begin
            pop_check("b2b_pt");
            due = (due_q.size() > 0) ? due_q.pop_front() : -1;
            checks++;
            if (cyc_n != due) begin
               errors++;
               $display("FAIL b2b_timing: done at cycle %0d expected %0d", cyc_n, due);
            end
            got++;
         end
      end
      start = 1'b0;
      checks++;
      if (got != 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", got); end
   endtask

   task automatic test_keycache;
      run_block("cache_c1_a", C1_KEY, C1_CT, C1_PT);
      run_block("cache_c1_b", C1_KEY, C1_CT, C1_PT);
      run_block("cache_b_new", B_KEY, B_CT, B_PT);
      rst = 1'b1;
      cyc;
      rst = 1'b0;
      m_valid = 1'b0;
      run_block("cache_b_rst", B_KEY, B_CT, B_PT);
      run_block("cache_b_again", B_KEY, B_CT, B_PT);
   endtask

   initial begin
      test_reset;
      test_fips_c1;
      test_fips_b_hold;
      test_start_ignored;
      test_reset_mid;
      test_back_to_back;
      test_keycache;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/aes_dec_top.md
# aes_dec_top

Iterative AES-128 inverse cipher (FIPS-197 decryption): the counterpart to the `aes_top` encryption core, using the same start/busy/done transaction interface. It accepts a 128-bit key and ciphertext, expands the key schedule on chip, and runs ten inverse rounds at one round per clock. The plaintext result is held until the next transaction. It sits beside `aes_top` in the crypto subsystem and is verified with the same OpenSSL-generated vector flow, with the key/pt/ct roles reversed.

## Interface
- No parameters; the block is fixed to AES-128.
- `clk` input 1: single clock; all state changes on posedge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a decryption; sampled on posedge only while `busy`=0.
- `key` input 128: cipher key, byte 0 at [127:120]; sampled on the accepting edge.
- `ciphertext` input 128: input block, same byte order; sampled on the accepting edge.
- `busy` output 1: transaction in progress.
- `done` output 1: one-cycle pulse when `plaintext` becomes valid.
- `plaintext` output 128: result; held stable from `done` until the next accepted start.

## Operation
- FSM states: IDLE, KEYEXP, INIT, ROUND, FIN.
- IDLE:
  - On `start`=1, latch `key` and `ciphertext` and assert `busy`.
  - Go to KEYEXP, with a round counter loaded to 1.
- KEYEXP (10 cycles):
  - Each cycle computes rk[i] from rk[i-1] for i=1..10 (RotWord, forward SubWord, Rcon 01,02,04,08,10,20,40,80,1b,36).
  - Stores all 11 round keys in a register array; rk[0] is the key itself.
  - Then go to INIT.
- INIT (1 cycle): s <= ct ^ rk[10]; round counter <= 9.
- ROUND (9 cycles, r=9..1): s <= InvMixColumns(InvSubBytes(InvShiftRows(s)) ^ rk[r]).
- FIN (1 cycle):
  - `plaintext` <= InvSubBytes(InvShiftRows(s)) ^ rk[0].
  - Pulse `done`, drop `busy`, return to IDLE.
- Inverse S-box is a combinational submodule: GF(2^8) inverse (poly 0x11b) applied after the inverse affine transform. 16 instances for the state, 4 forward instances for the key schedule.
- `start` while `busy`=1 is ignored and produces no queued request.
- `start`=1 in the same cycle `done`=1 is accepted, since `busy` is already 0.
- Reset values:
  - state IDLE; `busy`=0, `done`=0, `plaintext`=0.
  - Round-key array and state register don't care.
  - Key-cache valid bit = 0.
- Reset mid-transaction: aborts immediately; all outputs take reset values on that edge; no `done` is issued.

## Timing
- Accepting edge E0; KEYEXP at E1..E10; INIT at E11; ROUND at E12..E20; FIN at E21.
- `busy`=1 from E0 through E21; it falls at E21.
- `done`=1 for exactly the cycle after E21.
- Start-to-done latency: 21 cycles, or 11 on a key-cache hit.
- Back-to-back throughput: one block per 22 cycles (start held high continuously).
- `plaintext` updates only at the FIN edge; it never shows intermediate round state.

## Configuration
- Macro `AES_DEC_KEYCACHE_EN`.
- Defined:
  - Keep a 128-bit copy of the last fully expanded key plus a valid bit.
  - On an accepted start with a matching key and valid=1, go IDLE->INIT directly, skipping KEYEXP (latency 11).
  - Valid is set when KEYEXP completes and cleared by `rst`.
  - A reset during KEYEXP must leave valid=0.
- Undefined: no cache logic; KEYEXP always runs; latency is always 21.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> pt 00112233445566778899aabbccddeeff, `done` 21 cycles after start.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> pt 3243f6a8885a308d313198a2e0370734; `plaintext` stays stable until the next start.
- Start pulsed at E5 of a running transaction -> ignored; exactly one `done`; result correct.
- `rst` at E8 of a transaction -> `busy`=0, `done`=0, `plaintext`=0 next cycle; a fresh C.1 run afterwards passes.
- With `AES_DEC_KEYCACHE_EN`: second C.1 block with the same key -> `done` after 11 cycles. A different key -> 21 cycles. The same key after `rst` -> 21 cycles.
- Vector loop: `vectors.txt` key/pt/ct lines fed as (key, ct), compared to pt; also `aes_top` output chained into this block -> original pt, 0 fails.
